// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the nibble-serial adder controller.
// The requester drives the operation; the controller returns status and the held result.
interface serial_adder_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  logic                   start;
  logic                   sub;
  logic [4*NIBBLES-1:0]   a;
  logic [4*NIBBLES-1:0]   b;
  logic                   c_in;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   s;
  logic                   c_out;
  logic                   overflow;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, s, c_out, overflow
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, s, c_out, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial add/subtract controller driving one 4-bit ripple-carry slice.
// Operands are latched on start; the result and flags update only on entry to DONE.
module serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic               clock,
  input  logic               resetn,
  serial_adder_ctrl_if.slave bus
);
  localparam int unsigned   W      = 4 * NIBBLES;
  localparam int unsigned   KW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic          carry;
  logic          sub_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  work;
  logic [W-1:0]  s_q;
  logic          c_out_q;
  logic          ovf_q;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [3:0]    b_eff;
  logic [3:0]    sum;
  logic [4:0]    cy;
  logic [W-1:0]  work_next;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (k == i[KW-1:0]) begin
        a_nib = a_q[i*4 +: 4];
        b_nib = b_q[i*4 +: 4];
      end
    end
  end

  // Four chained full-adder bits; subtraction inverts B here and the carry-in at start.
  always_comb begin
    b_eff = b_nib ^ {4{sub_q}};
    sum   = '0;
    cy    = '0;
    cy[0] = carry;
    for (int unsigned j = 0; j < 4; j++) begin
      sum[j]  = a_nib[j] ^ b_eff[j] ^ cy[j];
      cy[j+1] = (a_nib[j] & b_eff[j]) | (cy[j] & (a_nib[j] ^ b_eff[j]));
    end
  end

  always_comb begin
    work_next = work;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (k == i[KW-1:0]) begin
        work_next[i*4 +: 4] = sum;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      k       <= '0;
      carry   <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work    <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sub_q <= bus.sub;
            carry <= bus.c_in ^ bus.sub;
            k     <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          work  <= work_next;
          carry <= cy[4];
          if (k == K_LAST) begin
            // Result is published from the combinational next value so it is valid as DONE is entered;
            // cy[3] here is the carry into bit W-1.
            s_q     <= work_next;
            c_out_q <= cy[4];
            ovf_q   <= cy[3] ^ cy[4];
            k       <= '0;
            state   <= ST_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (state == ST_RUN);
  assign bus.done     = (state == ST_DONE);
  assign bus.s        = s_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed table, random ops against an
// arithmetic reference model, and multi-cycle handshake/reset corner cases.
module tb_serial_adder_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  serial_adder_ctrl_if #(.NIBBLES(N)) bus ();
  serial_adder_ctrl_if #(.NIBBLES(1)) bus1 ();

  serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus1)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] held_s;
  logic        held_c, held_v;
  logic [3:0]  held1_s;
  logic        held1_c, held1_v;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, flags from unsigned/signed range checks.
  function automatic void model(input int w, input longint a, input longint b,
                                input bit sub, input bit cin,
                                output longint s, output bit c, output bit v);
    longint m, half, u, sa, sb, sr, ci;
    m    = longint'(1) << w;
    half = m >> 1;
    ci   = cin ? 1 : 0;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    if (!sub) begin
      u  = a + b + ci;
      c  = (u >= m);
      sr = sa + sb + ci;
    end else begin
      u  = a - b - ci;
      c  = (a >= b + ci);
      sr = sa - sb - ci;
    end
    s = u & (m - 1);
    v = (sr >= half) || (sr < -half);
  endfunction

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic cin, input logic [15:0] es, input logic ec,
                       input logic ev, input string tag);
    @(negedge clock);
    bus.a = a; bus.b = b; bus.sub = sub; bus.c_in = cin; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.sub = 1'($urandom); bus.c_in = 1'($urandom);
    chk({tag, "_hs0"}, {bus.busy, bus.done}, 2'b10);
    for (int e = 1; e <= int'(N); e++) begin
      @(posedge clock); #1;
      if (e < int'(N)) begin
        chk({tag, "_run_hs"}, {bus.busy, bus.done}, 2'b10);
        chk({tag, "_held"}, {bus.s, bus.c_out, bus.overflow}, {held_s, held_c, held_v});
      end else begin
        chk({tag, "_done_hs"}, {bus.busy, bus.done}, 2'b01);
        chk({tag, "_s"}, bus.s, es);
        chk({tag, "_cv"}, {bus.c_out, bus.overflow}, {ec, ev});
      end
    end
    held_s = es; held_c = ec; held_v = ev;
    @(posedge clock); #1;
    chk({tag, "_idle_hs"}, {bus.busy, bus.done}, 2'b00);
  endtask

  task automatic do_op1(input logic [3:0] a, input logic [3:0] b, input logic sub,
                        input logic cin, input logic [3:0] es, input logic ec,
                        input logic ev, input string tag);
    @(negedge clock);
    bus1.a = a; bus1.b = b; bus1.sub = sub; bus1.c_in = cin; bus1.start = 1'b1;
    @(posedge clock); #1;
    bus1.start = 1'b0;
    bus1.a = 4'($urandom); bus1.b = 4'($urandom);
    chk({tag, "_hs0"}, {bus1.busy, bus1.done, bus1.s}, {2'b10, held1_s});
    @(posedge clock); #1;
    chk({tag, "_done"}, {bus1.busy, bus1.done, bus1.s, bus1.c_out, bus1.overflow},
        {2'b01, es, ec, ev});
    held1_s = es; held1_c = ec; held1_v = ev;
    @(posedge clock); #1;
    chk({tag, "_idle_hs"}, {bus1.busy, bus1.done}, 2'b00);
  endtask

  initial begin
    longint ms;
    bit     mc, mv;
    int     ndone;
    logic [15:0] ra, rb;
    logic        rsub, rcin;

    vecs[0] = '{16'h1234, 16'h0FCC, 1'b0, 1'b0, 16'h2200, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;

    // Reset held for two edges.
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out", {bus.s, bus.c_out, bus.overflow, bus.busy, bus.done}, '0);
    chk("reset_out1", {bus1.s, bus1.c_out, bus1.overflow, bus1.busy, bus1.done}, '0);
    @(negedge clock);
    resetn = 1'b1;
    held_s = '0; held_c = 1'b0; held_v = 1'b0;
    held1_s = '0; held1_c = 1'b0; held1_v = 1'b0;
    @(posedge clock); #1;
    chk("post_reset_idle", {bus.busy, bus.done, bus.s}, '0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
            vecs[i].s, vecs[i].c, vecs[i].v, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rsub = 1'($urandom); rcin = 1'($urandom);
      if (i % 8 == 0) ra = 16'h7FFF;
      if (i % 8 == 1) ra = 16'h8000;
      if (i % 8 == 2) rb = 16'hFFFF;
      model(W, longint'(ra), longint'(rb), rsub, rcin, ms, mc, mv);
      do_op(ra, rb, rsub, rcin, 16'(ms), mc, mv, $sformatf("rnd%0d", i));
    end

    // Start pulses during RUN are ignored.
    @(negedge clock);
    bus.a = 16'h0001; bus.b = 16'h0001; bus.sub = 1'b0; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int e = 4; e <= 14; e++) begin
      @(posedge clock); #1;
      if (bus.done) ndone++;
      if (e == 4) chk("ign_result", {bus.done, bus.s, bus.c_out, bus.overflow}, {1'b1, 16'h0002, 2'b00});
      if (e > 4) chk("ign_no_busy", bus.busy, 1'b0);
    end
    chk("ign_one_done", ndone, 1);
    held_s = 16'h0002; held_c = 1'b0; held_v = 1'b0;

    // Load nonzero flags, then reset mid-operation.
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "pre_rst");
    @(negedge clock);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.sub = 1'b0; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    chk("midrst_out", {bus.busy, bus.done, bus.s, bus.c_out, bus.overflow}, '0);
    resetn = 1'b1;
    ndone = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clock); #1;
      if (bus.done || bus.busy || bus.s != 16'h0) ndone++;
    end
    chk("midrst_quiet", ndone, 0);
    held_s = '0; held_c = 1'b0; held_v = 1'b0;
    do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, "after_rst");

    // Start held high relaunches as soon as IDLE is reached.
    @(negedge clock);
    bus.a = 16'h0001; bus.b = 16'h0002; bus.sub = 1'b0; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.b = 16'h0005;
    ndone = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clock); #1;
      if (e == 6) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) chk("hold_first", {e[7:0], bus.s}, {8'd4, 16'h0003});
        if (ndone == 2) chk("hold_second", {e[7:0], bus.s}, {8'd10, 16'h0006});
      end
    end
    chk("hold_two_done", ndone, 2);

    // Single-nibble instance.
    do_op1(4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1, "n1_ovf");
    do_op1(4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, "n1_wrap");
    do_op1(4'h8, 4'h1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, "n1_sub");
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15));
      rsub = 1'($urandom); rcin = 1'($urandom);
      model(4, longint'(ra), longint'(rb), rsub, rcin, ms, mc, mv);
      do_op1(ra[3:0], rb[3:0], rsub, rcin, 4'(ms), mc, mv, $sformatf("n1_rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Multi-cycle controller that sequences a single 4-bit ripple-carry full-adder slice to add or subtract two wide operands, one nibble per clock, LSB nibble first. A registered carry links consecutive nibbles. It sits between a requester (switch/key front end or another FSM) and the shared 4-bit adder datapath. It provides a start/busy/done handshake and holds the final sum, carry-out and signed overflow until the next operation.

## Interface
- NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES bits); legal range ≥ 1
- clock  in  1  rising-edge system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = add, 1 = subtract; latched with start
- a  in  W  operand A; latched with start
- b  in  W  operand B; latched with start
- c_in  in  1  carry-in (add) / borrow-in (subtract); latched with start
- busy  out  1  high while the operation is in progress (RUN)
- done  out  1  one-cycle pulse when the result is valid
- s  out  W  result; registered, held between operations
- c_out  out  1  carry out of bit W-1 (in subtract mode, 1 = no borrow)
- overflow  out  1  two's-complement overflow of the W-bit result

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1: latch a, b, sub; set nibble index k=0; set carry = c_in XOR sub; go to RUN.
- Subtract computes A - B - c_in as A + ~B + ~c_in.
- RUN, each cycle: operate on nibble k of the latched operands.
  - Compute a[k] + (b[k] XOR {4{sub}}) + carry through four chained full-adder bits.
  - Write the 4-bit sum into nibble k of the internal working register.
  - Update carry with the bit-3 carry-out; increment k.
- Carry into bit 3 of the top nibble (k = NIBBLES-1) is captured as c3.
- After the nibble k = NIBBLES-1 cycle, go to DONE.
- DONE: copy the working register to s; set c_out = final carry; set overflow = c3 XOR final carry. Pulse done, then return to IDLE.
- s, c_out and overflow change only on entry to DONE. They never expose partial results.
- start is ignored in RUN and DONE; no queuing.
- Inputs a, b, sub and c_in may change freely after the start cycle.
- sub only changes the latched operation. It does not alter s, c_out or overflow from the prior operation.
- Arithmetic is modulo 2^W; c_out and overflow carry the out-of-range information.

## Timing
- Reset (resetn=0 at a rising edge) takes effect regardless of state, including mid-RUN:
  - state = IDLE, k = 0, carry = 0, working register = 0
  - s = 0, c_out = 0, overflow = 0, busy = 0, done = 0
- The partial operation is discarded.
- Let E0 be the edge that samples start=1 in IDLE:
  - busy = 1 from after E0 through edge E_NIBBLES.
  - Nibble k is registered at edge E(k+1).
  - State is DONE after E_NIBBLES: done = 1, busy = 0, and s/c_out/overflow are valid.
  - done falls at E(NIBBLES+1); state returns to IDLE.
- Latency from start to done is NIBBLES+1 edges. Minimum start-to-start spacing is NIBBLES+2 cycles.
- A start held high continuously launches a new operation each time IDLE is reached.
- NIBBLES=1: RUN lasts exactly one cycle; overflow still uses the bit-3 carry-in vs carry-out.
- busy and done are never high in the same cycle. Both are low in IDLE.

## Test plan
- Reset: hold resetn=0 for 2 edges, then release. Required: s=0x0000, c_out=0, overflow=0, busy=0, done=0.
- Basic add (NIBBLES=4): a=0x1234, b=0x0FCC, sub=0, c_in=0. Required: busy for 4 cycles; done 5 edges after start; s=0x2200, c_out=0, overflow=0.
- Add boundaries: 0xFFFF+0x0001 → s=0x0000, c_out=1, overflow=0. 0x7FFF+0x0001 → s=0x8000, c_out=0, overflow=1.
- Subtract: 0x0005-0x0007 (c_in=0) → s=0xFFFE, c_out=0, overflow=0. 0x8000-0x0001 → s=0x7FFF, c_out=1, overflow=1. 0x0010-0x0001 with c_in=1 → s=0x000E.
- Ignored start: start 0x0001+0x0001. Pulse start with a=0xFFFF, b=0xFFFF on RUN cycles 2 and 3. Required: s=0x0002, a single done pulse, and no second operation.
- Reset mid-operation: start 0x1234+0x1111 and drive resetn=0 during nibble 2. Required: busy=0, done never pulses, s=0. A following start of 0x0003+0x0004 gives s=0x0007 with normal latency.
